// File: rtl/alu_mem_pkg.sv
// Shared constants for the accumulator-machine ALU/memory slice: default
// widths, ALU function encodings and instruction field positions.
package alu_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 13;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // Instruction layout: opcode in the top three bits, word address below.
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 13;
    localparam int ADDR_MSB = 12;
    localparam int ADDR_LSB = 0;

    // Even parity over one memory word.
    function automatic logic word_parity(input logic [DATA_W_DEF-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 4-function ALU with zero detect.
// Optional carry/overflow/negative flags are built when ALU_FLAGS_EN is defined.
module alu_core
    import alu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y,
`ifdef ALU_FLAGS_EN
    output logic              carry,
    output logic              ovf,
    output logic              neg,
`endif
    output logic              zero
);

    // Select the ALU function; add/sub wrap modulo 2**DATA_W.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_NOT: y = ~a;
            default: y = '0;
        endcase
    end

    // Zero detect on the result.
    always_comb begin
        zero = (y == '0);
    end

`ifdef ALU_FLAGS_EN
    // Flags: unsigned carry/borrow, signed overflow and sign of the result.
    always_comb begin
        carry = 1'b0;
        ovf   = 1'b0;
        neg   = y[DATA_W-1];
        case (op)
            ALU_ADD: begin
                // An add wrapped exactly when the result is below an operand.
                carry = (y < a);
                ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                carry = (a < b);
                ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            default: begin
                carry = 1'b0;
                ovf   = 1'b0;
            end
        endcase
    end
`endif

endmodule

// File: rtl/alu_mem_unit.sv
// Execution and storage core of the 16-bit accumulator machine: the ALU,
// a registered copy of its zero flag, and an 8K x 16 word memory with
// synchronous write and combinational, reset-gated read.
// Optional macro: ALU_FLAGS_EN adds carry/ovf/neg outputs.
module alu_mem_unit
    import alu_mem_pkg::*;
#(
    parameter int    DATA_W    = DATA_W_DEF,
    parameter int    ADDR_W    = ADDR_W_DEF,
    parameter int    DEPTH     = 8192,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    output logic              zero_q,
`ifdef ALU_FLAGS_EN
    output logic              carry,
    output logic              ovf,
    output logic              neg,
`endif
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] mem_rdata
);

    logic              zero_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .a     (alu_a),
        .b     (alu_b),
        .op    (alu_op),
        .y     (alu_out),
`ifdef ALU_FLAGS_EN
        .carry (carry),
        .ovf   (ovf),
        .neg   (neg),
`endif
        .zero  (zero)
    );

    // Power-up contents: zero everywhere.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = '0;
        end
    end

    // Next state for the registered zero flag.
    always_comb begin
        zero_d = zero;
    end

    // Capture zero every edge; cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    // Synchronous write; suppressed while reset is held. Contents are never
    // cleared by reset so the array carries no reset term.
    always_ff @(posedge clk) begin
        if (mem_write && rst_n) begin
            mem_q[mem_addr] <= mem_wdata;
        end else begin
            mem_q[mem_addr] <= mem_q[mem_addr];
        end
    end

    // Combinational read, forced to zero when not reading or in reset.
    always_comb begin
        mem_rdata = '0;
        if (mem_read && rst_n) begin
            mem_rdata = mem_q[mem_addr];
        end else begin
            mem_rdata = '0;
        end
    end

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: scoreboard queue of expected values,
// one task per scenario.
module tb_alu_mem_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic        zero;
    logic        zero_q;
`ifdef ALU_FLAGS_EN
    logic        carry;
    logic        ovf;
    logic        neg;
`endif
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_rdata;

    int total;
    int bad;

    logic [15:0] exp_q [$];
    logic [15:0] mem_model [int];
    logic [15:0] exp_v;

    alu_mem_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .zero      (zero),
        .zero_q    (zero_q),
`ifdef ALU_FLAGS_EN
        .carry     (carry),
        .ovf       (ovf),
        .neg       (neg),
`endif
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                              input logic [1:0] op);
        logic [16:0] s;
        case (op)
            2'd0: begin s = {1'b0, a} + {1'b0, b}; return s[15:0]; end
            2'd1: begin s = {1'b0, a} + {1'b0, ~b} + 17'd1; return s[15:0]; end
            2'd2: return a & b;
            default: return ~a;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        mem_addr = 13'd0; mem_wdata = 16'd0;
        alu_a = 16'd0; alu_b = 16'd0; alu_op = 2'd0;
        #1;
        total++;
        if (zero_q !== 1'b0) begin bad++; $display("FAIL reset_zero_q got=%b exp=0", zero_q); end
        total++;
        if (mem_rdata !== 16'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", mem_rdata); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (mem_rdata !== 16'd0) begin bad++; $display("FAIL powerup_zero got=%h exp=0000", mem_rdata); end
        mem_read = 1'b0;
    endtask

    task automatic test_alu();
        logic [15:0] ta [6] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'hF0F0, 16'h00FF, 16'h1234};
        logic [15:0] tb [6] = '{16'h0001, 16'h0001, 16'h0007, 16'h0FF0, 16'hABCD, 16'h1234};
        logic [1:0]  to [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        logic [15:0] te [6] = '{16'h8000, 16'h0000, 16'hFFFE, 16'h00F0, 16'hFF00, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            alu_a = ta[i]; alu_b = tb[i]; alu_op = to[i];
            exp_q.push_back(te[i]);
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (alu_out !== exp_v) begin bad++; $display("FAIL alu_vec%0d got=%h exp=%h", i, alu_out, exp_v); end
            total++;
            if (zero !== (exp_v == 16'd0)) begin bad++; $display("FAIL zero_vec%0d got=%b exp=%b", i, zero, (exp_v == 16'd0)); end
`ifdef ALU_FLAGS_EN
            if (i == 1) begin
                total++;
                if (carry !== 1'b1) begin bad++; $display("FAIL carry_wrap got=%b exp=1", carry); end
            end
            if (i == 0) begin
                total++;
                if (ovf !== 1'b1 || neg !== 1'b1) begin bad++; $display("FAIL ovf_neg got=%b%b exp=11", ovf, neg); end
            end
            if (i == 2) begin
                total++;
                if (carry !== 1'b1) begin bad++; $display("FAIL borrow got=%b exp=1", carry); end
            end
`endif
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            alu_a = 16'($urandom); alu_b = 16'($urandom); alu_op = 2'($urandom_range(0, 3));
            exp_q.push_back(model_alu(alu_a, alu_b, alu_op));
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (alu_out !== exp_v) begin bad++; $display("FAIL alu_rand%0d op=%0d got=%h exp=%h", i, alu_op, alu_out, exp_v); end
        end
    endtask

    task automatic test_zero_q();
        @(negedge clk);
        alu_a = 16'd1; alu_b = 16'd0; alu_op = 2'd0;
        @(posedge clk); #1;
        total++;
        if (zero_q !== 1'b0) begin bad++; $display("FAIL zq_pre got=%b exp=0", zero_q); end
        @(negedge clk);
        alu_a = 16'd0;
        #1;
        total++;
        if (zero !== 1'b1 || zero_q !== 1'b0) begin bad++; $display("FAIL zq_comb got=%b%b exp=10", zero, zero_q); end
        @(posedge clk); #1;
        total++;
        if (zero_q !== 1'b1) begin bad++; $display("FAIL zq_reg got=%b exp=1", zero_q); end
    endtask

    task automatic test_mem();
        @(negedge clk);
        mem_addr = 13'h1FFF; mem_wdata = 16'hBEEF; mem_write = 1'b1; mem_read = 1'b0;
        mem_model[13'h1FFF] = 16'hBEEF;
        #1;
        total++;
        if (mem_rdata !== 16'd0) begin bad++; $display("FAIL rd_gate_w got=%h exp=0000", mem_rdata); end
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1;
        exp_q.push_back(mem_model[13'h1FFF]);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (mem_rdata !== exp_v) begin bad++; $display("FAIL rd_top got=%h exp=%h", mem_rdata, exp_v); end
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        total++;
        if (mem_rdata !== 16'd0) begin bad++; $display("FAIL rd_gate got=%h exp=0000", mem_rdata); end
    endtask

    task automatic test_rdw();
        @(negedge clk);
        mem_addr = 13'd10; mem_wdata = 16'h1111; mem_write = 1'b1; mem_read = 1'b0;
        mem_model[10] = 16'h1111;
        @(negedge clk);
        mem_wdata = 16'h2222; mem_read = 1'b1;
        exp_q.push_back(mem_model[10]);
        mem_model[10] = 16'h2222;
        exp_q.push_back(mem_model[10]);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (mem_rdata !== exp_v) begin bad++; $display("FAIL rdw_old got=%h exp=%h", mem_rdata, exp_v); end
        @(posedge clk); #1;
        mem_write = 1'b0;
        exp_v = exp_q.pop_front();
        total++;
        if (mem_rdata !== exp_v) begin bad++; $display("FAIL rdw_new got=%h exp=%h", mem_rdata, exp_v); end
    endtask

    task automatic test_reset_mem();
        @(negedge clk);
        mem_addr = 13'd20; mem_wdata = 16'h5A5A; mem_write = 1'b1; mem_read = 1'b0;
        alu_a = 16'd0; alu_b = 16'd0; alu_op = 2'd0;
        mem_model[20] = 16'h5A5A;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1;
        #1;
        total++;
        if (zero_q !== 1'b1) begin bad++; $display("FAIL rst_pre_zq got=%b exp=1", zero_q); end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (zero_q !== 1'b0 || mem_rdata !== 16'd0) begin bad++; $display("FAIL rst_async got=%b/%h exp=0/0000", zero_q, mem_rdata); end
        alu_a = 16'h0003; alu_b = 16'h0004;
        #1;
        total++;
        if (alu_out !== 16'h0007) begin bad++; $display("FAIL rst_alu got=%h exp=0007", alu_out); end
        mem_wdata = 16'hDEAD; mem_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_q.push_back(mem_model[20]);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (mem_rdata !== exp_v) begin bad++; $display("FAIL rst_retain got=%h exp=%h", mem_rdata, exp_v); end
        // Mid-cycle release followed by a normal write on the next edge.
        @(negedge clk);
        rst_n = 1'b0; mem_read = 1'b0;
        #2;
        rst_n = 1'b1;
        mem_addr = 13'd21; mem_wdata = 16'h7777; mem_write = 1'b1;
        mem_model[21] = 16'h7777;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1;
        exp_q.push_back(mem_model[21]);
        #1;
        exp_v = exp_q.pop_front();
        total++;
        if (mem_rdata !== exp_v) begin bad++; $display("FAIL rst_release_wr got=%h exp=%h", mem_rdata, exp_v); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_addr = 13'(100 + i); mem_wdata = 16'($urandom); mem_write = 1'b1; mem_read = 1'b0;
            mem_model[100 + i] = mem_wdata;
            exp_q.push_back(mem_wdata);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_write = 1'b0; mem_read = 1'b1; mem_addr = 13'(100 + i);
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (mem_rdata !== exp_v) begin bad++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, mem_rdata, exp_v); end
        end
        @(negedge clk);
        mem_read = 1'b1; mem_addr = 13'h1FFF;
        #1;
        total++;
        if (mem_rdata !== mem_model[13'h1FFF]) begin bad++; $display("FAIL top_intact got=%h exp=%h", mem_rdata, mem_model[13'h1FFF]); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_empty got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu();
        test_zero_q();
        test_mem();
        test_rdw();
        test_reset_mem();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
